// File: rtl/mips_pkg.sv
// Shared MIPS load definitions: load operation encodings, load data register states and the
// primary opcodes the decoder maps onto load operations.
package mips_pkg;

  typedef enum logic [2:0] {
    OpLb  = 3'd0,
    OpLbu = 3'd1,
    OpLh  = 3'd2,
    OpLhu = 3'd3,
    OpLw  = 3'd4,
    OpLwl = 3'd5,
    OpLwr = 3'd6,
    OpLd  = 3'd7
  } load_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StFull = 2'd2,
    StErr  = 2'd3
  } ldr_state_t;

  localparam logic [5:0] OpcLb  = 6'h20;
  localparam logic [5:0] OpcLh  = 6'h21;
  localparam logic [5:0] OpcLwl = 6'h22;
  localparam logic [5:0] OpcLw  = 6'h23;
  localparam logic [5:0] OpcLbu = 6'h24;
  localparam logic [5:0] OpcLhu = 6'h25;
  localparam logic [5:0] OpcLwr = 6'h26;
  localparam logic [5:0] OpcLd  = 6'h37;

  function automatic load_op_t opcode_to_load_op(input logic [5:0] opc);
    load_op_t op;
    case (opc)
      OpcLb:   op = OpLb;
      OpcLbu:  op = OpLbu;
      OpcLh:   op = OpLh;
      OpcLhu:  op = OpLhu;
      OpcLwl:  op = OpLwl;
      OpcLwr:  op = OpLwr;
      OpcLd:   op = OpLd;
      default: op = OpLw;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational MIPS load alignment: lane extraction, sign/zero extension and LWL/LWR merge.
module load_align
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  load_op_t                        op,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [DATA_WIDTH-1:0]           rt,
  input  logic [DATA_WIDTH-1:0]           data,
  output logic [DATA_WIDTH-1:0]           result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;
  logic [31:0] mem32;
  logic [31:0] rt32;
  logic [31:0] lwl_le;
  logic [31:0] lwr_le;
  logic [31:0] lwl_v;
  logic [31:0] lwr_v;
  int unsigned off;
  int unsigned n;

  always_comb begin
    off = 32'(offset);
    n   = off & 32'd3;

    // Big-endian lane k sits at the top of the bus, so shift down from the MSB end.
    if (BIG_ENDIAN) begin
      byte_v = 8'(data >> (DATA_WIDTH - 8 - 8 * off));
      half_v = 16'(data >> (DATA_WIDTH - 16 - 16 * (off >> 1)));
      word_v = 32'(data >> (DATA_WIDTH - 32 - 32 * (off >> 2)));
    end else begin
      byte_v = 8'(data >> (8 * off));
      half_v = 16'(data >> (16 * (off >> 1)));
      word_v = 32'(data >> (32 * (off >> 2)));
    end

    mem32  = 32'(data);
    rt32   = 32'(rt);
    lwl_le = (mem32 << (8 * (3 - n))) | (rt32 & (32'hFFFF_FFFF >> (8 * (n + 1))));
    lwr_le = (mem32 >> (8 * n)) | (rt32 & ~(32'hFFFF_FFFF >> (8 * n)));
    lwl_v  = BIG_ENDIAN ? lwr_le : lwl_le;
    lwr_v  = BIG_ENDIAN ? lwl_le : lwr_le;

    result = data;
    unique case (op)
      OpLb:  result = DATA_WIDTH'($signed(byte_v));
      OpLbu: result = DATA_WIDTH'(byte_v);
      OpLh:  result = DATA_WIDTH'($signed(half_v));
      OpLhu: result = DATA_WIDTH'(half_v);
      OpLw:  result = DATA_WIDTH'($signed(word_v));
      // The partial-word merges only exist on the 32-bit bus; wider buses fall back to LW.
      OpLwl: result = (DATA_WIDTH == 32) ? DATA_WIDTH'(lwl_v) : DATA_WIDTH'($signed(word_v));
      OpLwr: result = (DATA_WIDTH == 32) ? DATA_WIDTH'(lwr_v) : DATA_WIDTH'($signed(word_v));
      OpLd:  result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_data_register.sv
// Load data register: captures aligned memory load responses on a valid strobe, holds them
// under a valid/ack handshake and flags responses that never arrive.
module load_data_register
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_start,
  input  logic [2:0]                      load_op,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] byte_offset,
  input  logic [DATA_WIDTH-1:0]           rt_data,
  input  logic [DATA_WIDTH-1:0]           mem_readdata,
  input  logic                            mem_readdatavalid,
  input  logic                            dr_ack,
  output logic [DATA_WIDTH-1:0]           dr_readdata,
  output logic                            dr_valid,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int unsigned OffW = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  ldr_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  load_op_t              op_q, op_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [DATA_WIDTH-1:0] rt_q, rt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  accept_start;
  load_op_t              align_op;
  logic [OffW-1:0]       align_off;
  logic [DATA_WIDTH-1:0] align_rt;
  logic [DATA_WIDTH-1:0] align_result;

  // A load issued this cycle has no registered context yet, so align from the live inputs.
  always_comb begin
    accept_start = load_start && ((state_q == StIdle) || ((state_q == StFull) && dr_ack));
    align_op     = accept_start ? load_op_t'(load_op) : op_q;
    align_off    = accept_start ? byte_offset : off_q;
    align_rt     = accept_start ? rt_data : rt_q;
  end

  load_align #(
    .DATA_WIDTH(DATA_WIDTH),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .op    (align_op),
    .offset(align_off),
    .rt    (align_rt),
    .data  (mem_readdata),
    .result(align_result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    off_d   = off_q;
    rt_d    = rt_q;
    data_d  = data_q;

    if (accept_start) begin
      op_d  = load_op_t'(load_op);
      off_d = byte_offset;
      rt_d  = rt_data;
    end

    unique case (state_q)
      StIdle, StFull: begin
        if ((state_q == StFull) && dr_ack) begin
          state_d = StIdle;
        end
        if (accept_start) begin
          cnt_d = '0;
          if (mem_readdatavalid) begin
            data_d  = align_result;
            state_d = StFull;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_readdatavalid) begin
          data_d  = align_result;
          state_d = StFull;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((WAIT_LIMIT > 0) && (32'(cnt_d) == WAIT_LIMIT)) begin
            state_d = StErr;
          end
        end
      end
      StErr: begin
        if (dr_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpLb;
      off_q   <= '0;
      rt_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      off_q   <= off_d;
      rt_q    <= rt_d;
      data_q  <= data_d;
    end
  end

  assign dr_readdata = data_q;
  assign dr_valid    = (state_q == StFull);
  assign busy        = (state_q == StWait);
  assign timeout_err = (state_q == StErr);

endmodule

// File: tb/tb_load_data_register.sv
// Directed bench for load_data_register: a little-endian and a big-endian instance share stimulus.
module tb_load_data_register;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [2:0]  load_op;
  logic [1:0]  byte_offset;
  logic [31:0] rt_data;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        dr_ack;
  logic [31:0] dr_readdata;
  logic        dr_valid;
  logic        busy;
  logic        timeout_err;
  logic [31:0] be_readdata;
  logic        be_valid;
  logic        be_busy;
  logic        be_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  load_data_register #(
    .DATA_WIDTH(32),
    .BIG_ENDIAN(1'b0),
    .WAIT_LIMIT(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_op          (load_op),
    .byte_offset      (byte_offset),
    .rt_data          (rt_data),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .dr_ack           (dr_ack),
    .dr_readdata      (dr_readdata),
    .dr_valid         (dr_valid),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  load_data_register #(
    .DATA_WIDTH(32),
    .BIG_ENDIAN(1'b1),
    .WAIT_LIMIT(4)
  ) dut_be (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_op          (load_op),
    .byte_offset      (byte_offset),
    .rt_data          (rt_data),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .dr_ack           (dr_ack),
    .dr_readdata      (be_readdata),
    .dr_valid         (be_valid),
    .busy             (be_busy),
    .timeout_err      (be_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_full(input string tag, input logic [31:0] exp_le, input logic [31:0] exp_be);
    check({tag, " valid"}, 32'(dr_valid), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " data"}, dr_readdata, exp_le);
    check({tag, " be valid"}, 32'(be_valid), 32'd1);
    check({tag, " be data"}, be_readdata, exp_be);
  endtask

  task automatic ack();
    dr_ack = 1'b1;
    tick();
    dr_ack = 1'b0;
    check("ack valid", 32'(dr_valid), 32'd0);
    check("ack be valid", 32'(be_valid), 32'd0);
  endtask

  // Issue a load whose response arrives in the last of `waits` WAIT cycles (0 = same cycle).
  task automatic run_load(input string tag, input logic [2:0] op, input logic [1:0] off,
                          input logic [31:0] rt, input logic [31:0] mem, input int waits,
                          input logic [31:0] exp_le, input logic [31:0] exp_be);
    load_op           = op;
    byte_offset       = off;
    rt_data           = rt;
    mem_readdata      = mem;
    load_start        = 1'b1;
    mem_readdatavalid = (waits == 0);
    tick();
    load_start        = 1'b0;
    mem_readdatavalid = 1'b0;
    // Live context is scrambled; capture must use the registered copy.
    load_op           = 3'd7;
    byte_offset       = ~off;
    rt_data           = ~rt;
    for (int i = 0; i < waits; i++) begin
      check({tag, " wait busy"}, 32'(busy), 32'd1);
      if (i == waits - 1) mem_readdatavalid = 1'b1;
      tick();
      mem_readdatavalid = 1'b0;
    end
    check_full(tag, exp_le, exp_be);
    tick();
    check_full({tag, " hold"}, exp_le, exp_be);
    ack();
  endtask

  initial begin
    reset             = 1'b0;
    load_start        = 1'b0;
    load_op           = 3'd0;
    byte_offset       = 2'd0;
    rt_data           = 32'd0;
    mem_readdata      = 32'd0;
    mem_readdatavalid = 1'b0;
    dr_ack            = 1'b0;
    #12;
    check("reset valid", 32'(dr_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset timeout", 32'(timeout_err), 32'd0);
    check("reset data", dr_readdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    run_load("lb off3", 3'd0, 2'd3, 32'd0, 32'h80FF_1234, 2, 32'hFFFF_FF80, 32'h0000_0034);
    run_load("lbu off3", 3'd1, 2'd3, 32'd0, 32'h80FF_1234, 1, 32'h0000_0080, 32'h0000_0034);
    run_load("lhu off2", 3'd3, 2'd2, 32'd0, 32'h80FF_1234, 1, 32'h0000_80FF, 32'h0000_1234);
    run_load("lh off2", 3'd2, 2'd2, 32'd0, 32'h80FF_1234, 3, 32'hFFFF_80FF, 32'h0000_1234);
    run_load("lh off0 zw", 3'd2, 2'd0, 32'd0, 32'h80FF_1234, 0, 32'h0000_1234, 32'hFFFF_80FF);
    run_load("lwl off1", 3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 1, 32'h3344_CCDD,
             32'hAA11_2233);
    run_load("lwr off1", 3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 1, 32'hAA11_2233,
             32'h3344_CCDD);

    // Back-to-back: ack, new load and its response all in the same cycle.
    load_op           = 3'd4;
    byte_offset       = 2'd0;
    mem_readdata      = 32'h0000_1234;
    load_start        = 1'b1;
    mem_readdatavalid = 1'b1;
    tick();
    check_full("lw first", 32'h0000_1234, 32'h0000_1234);
    dr_ack       = 1'b1;
    mem_readdata = 32'hCAFE_F00D;
    tick();
    dr_ack            = 1'b0;
    load_start        = 1'b0;
    mem_readdatavalid = 1'b0;
    check_full("lw b2b", 32'hCAFE_F00D, 32'hCAFE_F00D);
    ack();

    // Timeout after four silent WAIT cycles.
    load_op      = 3'd4;
    mem_readdata = 32'h5555_5555;
    load_start   = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to busy", 32'(busy), 32'd1);
      check("to no err", 32'(timeout_err), 32'd0);
      tick();
    end
    check("to err", 32'(timeout_err), 32'd1);
    check("to busy low", 32'(busy), 32'd0);
    check("to valid", 32'(dr_valid), 32'd0);
    check("to data kept", dr_readdata, 32'hCAFE_F00D);
    load_start        = 1'b1;
    mem_readdatavalid = 1'b1;
    tick();
    load_start        = 1'b0;
    mem_readdatavalid = 1'b0;
    check("late err", 32'(timeout_err), 32'd1);
    check("late valid", 32'(dr_valid), 32'd0);
    check("late data", dr_readdata, 32'hCAFE_F00D);
    dr_ack = 1'b1;
    tick();
    dr_ack = 1'b0;
    check("err ack", 32'(timeout_err), 32'd0);
    check("err ack valid", 32'(dr_valid), 32'd0);
    check("err ack busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    load_op    = 3'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("pre-rst busy", 32'(busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async busy", 32'(busy), 32'd0);
    check("async valid", 32'(dr_valid), 32'd0);
    check("async timeout", 32'(timeout_err), 32'd0);
    check("async data", dr_readdata, 32'd0);
    @(negedge clk);
    reset             = 1'b1;
    mem_readdata      = 32'hDEAD_BEEF;
    mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    check("idle rsp valid", 32'(dr_valid), 32'd0);
    check("idle rsp data", dr_readdata, 32'd0);
    check("idle rsp busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
